// File: rtl/ram_sdp_be.sv
// rtl/ram_sdp_be.sv - simple dual-port RAM with byte enables, RDW policy, optional output register and clear sequencer
module ram_sdp_be #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 4,
  parameter int DEPTH     = 16,
  parameter int RD_BYPASS = 0,
  parameter int OUT_REG   = 0
) (
  input  logic                clock,
  input  logic                rst,
  input  logic                wen,
  input  logic [ADDR_W-1:0]   w_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic                ren,
  input  logic [ADDR_W-1:0]   r_addr,
  input  logic                clr,
  output logic [DATA_W-1:0]   dout,
  output logic                rd_valid,
  output logic                busy,
  output logic                addr_err
);

  localparam int NB = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_V   = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {
    S_CLEAR,
    S_READY
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              w_in, r_in;
  logic              w_ok, r_ok;
  logic [DATA_W-1:0] w_merged;
  logic [DATA_W-1:0] rd_data_d;
  logic              addr_err_d;

  logic [DATA_W-1:0] dout1_q;
  logic              vld1_q;
  logic              addr_err_q;

  // Requests are honoured only in READY; addresses at or beyond DEPTH never touch the array.
  assign busy = (state_q == S_CLEAR);
  assign w_in = ({1'b0, w_addr} < DEPTH_V);
  assign r_in = ({1'b0, r_addr} < DEPTH_V);
  assign w_ok = !busy && wen && w_in;
  assign r_ok = !busy && ren;

  // Clear sequencer next state: sweep clr_addr 0..DEPTH-1, restart on clr.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      S_CLEAR: begin
        if (clr) begin
          clr_addr_d = '0;
        end else if (clr_addr_q == LAST_ADDR) begin
          clr_addr_d = '0;
          state_d    = S_READY;
        end else begin
          clr_addr_d = clr_addr_q + ADDR_W'(1);
        end
      end
      S_READY: begin
        if (clr) begin
          state_d    = S_CLEAR;
          clr_addr_d = '0;
        end
      end
      default: begin
        state_d    = S_CLEAR;
        clr_addr_d = '0;
      end
    endcase
  end

  // Sequencer state register; reset parks it at the start of a clear sweep.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q    <= S_CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  // Byte-merge the write data into the current word; also serves as the bypass value.
  always_comb begin
    w_merged = mem_q[w_addr];
    for (int k = 0; k < NB; k++) begin
      if (wr_be[k]) begin
        w_merged[8*k +: 8] = wr_data[8*k +: 8];
      end
    end
  end

  // Read word selection: out-of-range reads return zero, same-address reads honour the RDW policy.
  always_comb begin
    rd_data_d = '0;
    if (r_in) begin
      if ((RD_BYPASS != 0) && w_ok && (w_addr == r_addr)) begin
        rd_data_d = w_merged;
      end else begin
        rd_data_d = mem_q[r_addr];
      end
    end
  end

  // One error pulse per cycle even when both ports are out of range.
  always_comb begin
    addr_err_d = !busy && ((wen && !w_in) || (ren && !r_in));
  end

  // Array write port: the clear sweep owns the port while busy.
  always_ff @(posedge clock) begin
    if (state_q == S_CLEAR) begin
      mem_q[clr_addr_q] <= '0;
    end else if (w_ok) begin
      mem_q[w_addr] <= w_merged;
    end
  end

  // First read stage: dout holds its value when no read is accepted.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      dout1_q    <= '0;
      vld1_q     <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      vld1_q     <= r_ok;
      addr_err_q <= addr_err_d;
      if (r_ok) begin
        dout1_q <= rd_data_d;
      end
    end
  end

  assign addr_err = addr_err_q;

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [DATA_W-1:0] dout2_q;
      logic              vld2_q;

      // Optional output register: delays data and valid by one more cycle.
      always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
          dout2_q <= '0;
          vld2_q  <= 1'b0;
        end else begin
          vld2_q <= vld1_q;
          if (vld1_q) begin
            dout2_q <= dout1_q;
          end
        end
      end

      assign dout     = dout2_q;
      assign rd_valid = vld2_q;
    end else begin : g_noreg
      assign dout     = dout1_q;
      assign rd_valid = vld1_q;
    end
  endgenerate

endmodule

// File: tb/tb_ram_sdp_be.sv
// tb/tb_ram_sdp_be.sv - scoreboard bench for ram_sdp_be in two configurations
`timescale 1ns/1ps
module tb_ram_sdp_be;

  logic        clock = 1'b0;
  logic        rst;
  logic        wen;
  logic [3:0]  w_addr;
  logic [15:0] wr_data;
  logic [1:0]  wr_be;
  logic        ren;
  logic [3:0]  r_addr;
  logic        clr;

  logic [15:0] a_dout;
  logic        a_rd_valid, a_busy, a_addr_err;
  logic [7:0]  b_dout;
  logic        b_rd_valid, b_busy, b_addr_err;

  int tests = 0;
  int fails = 0;

  // A: 16-bit, 16 deep, old-data RDW, latency 1
  ram_sdp_be #(.DATA_W(16), .ADDR_W(4), .DEPTH(16), .RD_BYPASS(0), .OUT_REG(0)) dut_a (
    .clock(clock), .rst(rst), .wen(wen), .w_addr(w_addr), .wr_data(wr_data),
    .wr_be(wr_be), .ren(ren), .r_addr(r_addr), .clr(clr),
    .dout(a_dout), .rd_valid(a_rd_valid), .busy(a_busy), .addr_err(a_addr_err)
  );

  // B: 8-bit, 12 deep, new-data RDW, latency 2
  ram_sdp_be #(.DATA_W(8), .ADDR_W(4), .DEPTH(12), .RD_BYPASS(1), .OUT_REG(1)) dut_b (
    .clock(clock), .rst(rst), .wen(wen), .w_addr(w_addr), .wr_data(wr_data[7:0]),
    .wr_be(wr_be[0]), .ren(ren), .r_addr(r_addr), .clr(clr),
    .dout(b_dout), .rd_valid(b_rd_valid), .busy(b_busy), .addr_err(b_addr_err)
  );

  always #5 clock = ~clock;

  logic [15:0] ma [16];
  logic [7:0]  mb [12];
  int          a_cnt, b_cnt;
  logic        b_pend;
  logic [15:0] qa [$];
  logic [7:0]  qb [$];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; wen = 0; w_addr = 0; wr_data = 0; wr_be = 0; ren = 0; r_addr = 0; clr = 0;
    @(posedge clock); #1;
    chk("rst_a_dout", a_dout, 16'h0);
    chk("rst_a_valid", {15'b0, a_rd_valid}, 16'h0);
    chk("rst_a_busy", {15'b0, a_busy}, 16'h1);
    chk("rst_a_err", {15'b0, a_addr_err}, 16'h0);
    chk("rst_b_dout", {8'b0, b_dout}, 16'h0);
    chk("rst_b_valid", {15'b0, b_rd_valid}, 16'h0);
    chk("rst_b_busy", {15'b0, b_busy}, 16'h1);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) ma[i] = '0;
    for (int i = 0; i < 12; i++) mb[i] = '0;
    a_cnt = 16; b_cnt = 12; b_pend = 1'b0;
    qa.delete(); qb.delete();
  endtask

  task automatic step(input logic i_wen, input logic [3:0] i_wa, input logic [15:0] i_wd,
                      input logic [1:0] i_be, input logic i_ren, input logic [3:0] i_ra,
                      input logic i_clr);
    logic a_acc, b_acc, a_rv, b_rv, a_err, b_err;
    logic [15:0] rd_a;
    logic [7:0]  rd_b;
    wen = i_wen; w_addr = i_wa; wr_data = i_wd; wr_be = i_be;
    ren = i_ren; r_addr = i_ra; clr = i_clr;
    a_acc = (a_cnt == 0);
    b_acc = (b_cnt == 0);
    chk("a_busy", {15'b0, a_busy}, {15'b0, !a_acc});
    chk("b_busy", {15'b0, b_busy}, {15'b0, !b_acc});
    // A model: read sees old data, then write lands
    a_rv = a_acc && i_ren;
    a_err = 1'b0;
    if (a_rv) begin
      rd_a = ma[i_ra];
      qa.push_back(rd_a);
    end
    if (a_acc && i_wen) begin
      if (i_be[0]) ma[i_wa][7:0]  = i_wd[7:0];
      if (i_be[1]) ma[i_wa][15:8] = i_wd[15:8];
    end
    // B model: write lands first so a same-address read sees new data
    b_err = b_acc && ((i_wen && i_wa >= 12) || (i_ren && i_ra >= 12));
    if (b_acc && i_wen && i_wa < 12 && i_be[0]) mb[i_wa] = i_wd[7:0];
    if (b_acc && i_ren) begin
      rd_b = (i_ra < 12) ? mb[i_ra] : 8'h00;
      qb.push_back(rd_b);
    end
    b_rv = b_pend;
    b_pend = b_acc && i_ren;
    if (i_clr) begin
      a_cnt = 16; b_cnt = 12;
      for (int i = 0; i < 16; i++) ma[i] = '0;
      for (int i = 0; i < 12; i++) mb[i] = '0;
    end else begin
      if (a_cnt > 0) a_cnt--;
      if (b_cnt > 0) b_cnt--;
    end
    @(posedge clock); #1;
    chk("a_rd_valid", {15'b0, a_rd_valid}, {15'b0, a_rv});
    chk("a_addr_err", {15'b0, a_addr_err}, {15'b0, a_err});
    chk("b_rd_valid", {15'b0, b_rd_valid}, {15'b0, b_rv});
    chk("b_addr_err", {15'b0, b_addr_err}, {15'b0, b_err});
    if (a_rv && qa.size() > 0) chk("a_dout", a_dout, qa.pop_front());
    if (b_rv && qb.size() > 0) chk("b_dout", {8'b0, b_dout}, {8'b0, qb.pop_front()});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'h0, 16'h0, 2'b00, 1'b0, 4'h0, 1'b0);
  endtask

  initial begin
    // reset and initial clear sweep
    do_reset();
    idle(17);
    // every location reads zero; B addresses 12..15 are out of range
    for (int i = 0; i < 16; i++) step(1'b0, 4'h0, 16'h0, 2'b00, 1'b1, 4'(i), 1'b0);
    idle(2);
    // byte-enable merge
    step(1'b1, 4'h3, 16'h1234, 2'b11, 1'b0, 4'h0, 1'b0);
    step(1'b1, 4'h3, 16'hFF00, 2'b10, 1'b0, 4'h0, 1'b0);
    step(1'b1, 4'h5, 16'h00A5, 2'b01, 1'b1, 4'h3, 1'b0);
    step(1'b1, 4'h6, 16'h9999, 2'b00, 1'b1, 4'h5, 1'b0);
    step(1'b0, 4'h0, 16'h0, 2'b00, 1'b1, 4'h6, 1'b0);
    idle(2);
    // read-during-write to the same address
    step(1'b1, 4'h7, 16'h0011, 2'b11, 1'b0, 4'h0, 1'b0);
    step(1'b1, 4'h7, 16'h005A, 2'b11, 1'b1, 4'h7, 1'b0);
    step(1'b0, 4'h0, 16'h0, 2'b00, 1'b1, 4'h7, 1'b0);
    idle(2);
    // back-to-back reads
    step(1'b1, 4'h1, 16'h0101, 2'b11, 1'b0, 4'h0, 1'b0);
    step(1'b1, 4'h2, 16'h0202, 2'b11, 1'b0, 4'h0, 1'b0);
    step(1'b0, 4'h0, 16'h0, 2'b00, 1'b1, 4'h1, 1'b0);
    step(1'b0, 4'h0, 16'h0, 2'b00, 1'b1, 4'h2, 1'b0);
    step(1'b0, 4'h0, 16'h0, 2'b00, 1'b1, 4'h3, 1'b0);
    idle(3);
    // out-of-range write and read on B, then the last valid address
    step(1'b1, 4'hD, 16'hEEEE, 2'b11, 1'b1, 4'hE, 1'b0);
    step(1'b1, 4'hB, 16'h00C3, 2'b11, 1'b0, 4'h0, 1'b0);
    step(1'b0, 4'h0, 16'h0, 2'b00, 1'b1, 4'hB, 1'b0);
    step(1'b0, 4'h0, 16'h0, 2'b00, 1'b1, 4'hD, 1'b0);
    idle(2);
    // fill, clear, traffic while busy, then everything reads zero
    for (int i = 0; i < 16; i++) step(1'b1, 4'(i), 16'(i * 16'h1111 + 1), 2'b11, 1'b0, 4'h0, 1'b0);
    step(1'b0, 4'h0, 16'h0, 2'b00, 1'b0, 4'h0, 1'b1);
    for (int i = 0; i < 17; i++) step(1'b1, 4'(i), 16'hFFFF, 2'b11, 1'b1, 4'(i), 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, 4'h0, 16'h0, 2'b00, 1'b1, 4'(i), 1'b0);
    idle(2);
    // clr during a clear restarts the sweep
    step(1'b1, 4'h4, 16'h4444, 2'b11, 1'b0, 4'h0, 1'b0);
    step(1'b0, 4'h0, 16'h0, 2'b00, 1'b0, 4'h0, 1'b1);
    idle(3);
    step(1'b0, 4'h0, 16'h0, 2'b00, 1'b0, 4'h0, 1'b1);
    idle(17);
    // reset in the middle of a clear restarts the full sweep
    step(1'b0, 4'h0, 16'h0, 2'b00, 1'b0, 4'h0, 1'b1);
    idle(5);
    do_reset();
    idle(17);
    step(1'b0, 4'h0, 16'h0, 2'b00, 1'b1, 4'h4, 1'b0);
    idle(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ram_sdp_be.md
Name: ram_sdp_be

Overview:
- Parametrised simple dual-port synchronous RAM: one write port and one read port on a single clock.
- Adds per-byte write enables, a selectable read-during-write policy, an optional output register stage and a hardware clear sequencer.
- The sequencer zeroes the whole array after reset or on request.
- Used as a generic buffer/lookup store by datapath and FIFO blocks.

Parameters:
DATA_W, 8, data width in bits; must be a multiple of 8
ADDR_W, 4, address width in bits
DEPTH, 16, number of words; 1 <= DEPTH <= 2**ADDR_W
RD_BYPASS, 0, 0 = read-during-write to same address returns old data; 1 = returns newly written data
OUT_REG, 0, 0 = read latency 1; 1 = extra output register, read latency 2

Ports:
clock  in  1  rising-edge clock
rst  in  1  asynchronous reset, active high
wen  in  1  write request
w_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
wr_be  in  DATA_W/8  byte enables; bit k qualifies wr_data[8k+7:8k]
ren  in  1  read request
r_addr  in  ADDR_W  read address
clr  in  1  single-cycle request to zero the whole array
dout  out  DATA_W  read data
rd_valid  out  1  dout carries fresh read data this cycle
busy  out  1  clear sequencer active; port requests ignored
addr_err  out  1  one-cycle pulse: an accepted request used address >= DEPTH

Behaviour:
- Reset is one clock domain, asynchronous and active-high.
- rst asserted → dout=0, rd_valid=0, addr_err=0, any OUT_REG pipeline stage=0, FSM=CLEAR, clr_addr=0, busy=1.
- Array is not reset asynchronously; the CLEAR state zeroes it.
- FSM states: CLEAR and READY.
  - CLEAR: each clock writes 0 to mem[clr_addr], then clr_addr++.
  - At clr_addr==DEPTH-1 the write completes and FSM → READY on the same edge.
  - Clear therefore takes exactly DEPTH cycles after rst deassertion.
  - busy=1 in CLEAR, 0 in READY (combinational from state).
  - clr in READY → CLEAR, clr_addr=0, on the next edge.
  - clr in CLEAR → clr_addr restarts at 0.
  - rst mid-clear → restart from 0.
- While busy: wen, ren and clr-independent traffic are ignored. No write occurs, rd_valid stays 0, dout holds.
- Write (READY, wen=1, w_addr<DEPTH): on the edge, byte k of mem[w_addr] ← wr_data byte k where wr_be[k]=1; other bytes unchanged. wr_be all zero → no change, not an error.
- Read (READY, ren=1, r_addr<DEPTH):
  - OUT_REG=0: dout updates on the sampling edge; rd_valid=1 for the following cycle.
  - OUT_REG=1: data passes an extra register; dout/rd_valid appear one cycle later.
  - Back-to-back reads give one result per cycle.
- No read: dout holds its last value; rd_valid=0.
- Same-cycle read and write to the same address:
  - RD_BYPASS=0: dout = pre-write contents.
  - RD_BYPASS=1: dout = post-write merged word, i.e. new bytes where wr_be=1, old bytes elsewhere.
- Different addresses: fully independent.
- Out-of-range address (>= DEPTH), READY state:
  - Write is dropped.
  - Read returns dout=0 with rd_valid asserted normally.
  - addr_err pulses one cycle, aligned with the cycle after the request edge. If both ports are out of range, a single pulse.
- Address arithmetic: clr_addr is ADDR_W bits; no wrap beyond DEPTH-1.

Test Plan:
- Reset release, DEPTH=16, OUT_REG=0 → busy=1 for exactly 16 cycles then 0. Read addresses 0..15 → all dout=0x00, rd_valid=1 each following cycle.
- Write 0xA5 to addr 3 with wr_be=1, then read addr 3 → dout=0xA5 one cycle later. With DATA_W=16: write 0x1234 at addr 3, then wr_be=2'b10 with 0xFF00 → read returns 0xFF34.
- Same-cycle write 0x5A / read addr 7, where addr 7 holds 0x11 → dout=0x11 with RD_BYPASS=0; dout=0x5A with RD_BYPASS=1.
- OUT_REG=1: reads of addrs 1,2,3 on consecutive cycles → dout sequence appears 2 cycles after each request, one per cycle, rd_valid high 3 cycles.
- clr pulse after filling memory, plus wen/ren during busy → busy 16 cycles, no writes land, rd_valid stays 0. Afterwards all locations read 0. rst asserted at clear cycle 5 → busy restarts full 16 cycles.
- DEPTH=12, ADDR_W=4: write addr 13 and read addr 14 → addr_err single pulse, dout=0, memory unchanged.
